// File: rtl/adc_word_align_if.sv
// adc_word_align_if: lane inputs, training control and aligned-output bundle for adc_word_align
interface adc_word_align_if #(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int PATH_NUM = 2
);
  logic [ADC_DATA_WIDTH*PATH_NUM-1:0] adc_in_H;
  logic [ADC_DATA_WIDTH*PATH_NUM-1:0] adc_in_L;
  logic train_start;
  logic [ADC_DATA_WIDTH*2*PATH_NUM-1:0] adc_o;
  logic adc_o_valid;
  logic locked;
  logic align_fail;
  logic [1:0] align_cfg;
  modport master (
    output adc_in_H, adc_in_L, train_start,
    input adc_o, adc_o_valid, locked, align_fail, align_cfg
  );
  modport slave (
    input adc_in_H, adc_in_L, train_start,
    output adc_o, adc_o_valid, locked, align_fail, align_cfg
  );
endinterface

// File: rtl/adc_word_align.sv
// adc_word_align: finds H/L lane order and one-word L skew from a ramp pattern, then emits aligned words
module adc_word_align #(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int PATH_NUM = 2,
  parameter int CHECK_LEN = 64,
  parameter int WINDOW = 256
) (
  input logic clk,
  input logic rst_n,
  adc_word_align_if.slave bus
);
  localparam int W = ADC_DATA_WIDTH;
  localparam int N = 2 * PATH_NUM;
  localparam int PW = $clog2(CHECK_LEN + 1);
  localparam int WW = $clog2(WINDOW);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [PW-1:0] PMAX = PW'(CHECK_LEN);
  localparam logic [WW-1:0] WMAX = WW'(WINDOW - 1);
  typedef enum logic [1:0] {IDLE, TRAIN, LOCKED, FAIL} state_t;
  state_t state;
  logic [W*PATH_NUM-1:0] h_r, l_r, l_d, l_src;
  logic [W*N-1:0] cand;
  logic [W-1:0] last_r;
  logic [1:0] cfg;
  logic [WW-1:0] wcnt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic pass;
  assign l_src = cfg[1] ? l_d : l_r;
  for (genvar i = 0; i < PATH_NUM; i++) begin : g_mux
    assign cand[2*i*W +: W] = cfg[0] ? l_src[i*W +: W] : h_r[i*W +: W];
    assign cand[(2*i+1)*W +: W] = cfg[0] ? h_r[i*W +: W] : l_src[i*W +: W];
  end
  // last_r carries the previous word's final sample so the ramp is checked across word boundaries
  always_comb begin
    pass = cand[0 +: W] == last_r + ONE;
    for (int k = 0; k < N - 1; k++) pass = pass && (cand[(k+1)*W +: W] == cand[k*W +: W] + ONE);
    pcnt_nxt = !pass ? '0 : pcnt == PMAX ? pcnt : pcnt + 1'b1;
  end
  assign bus.align_cfg = cfg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      h_r <= '0;
      l_r <= '0;
      l_d <= '0;
      last_r <= '0;
      cfg <= '0;
      wcnt <= '0;
      pcnt <= '0;
      bus.adc_o <= '0;
      bus.adc_o_valid <= 1'b0;
      bus.locked <= 1'b0;
      bus.align_fail <= 1'b0;
    end else begin
      h_r <= bus.adc_in_H;
      l_r <= bus.adc_in_L;
      l_d <= l_r;
      last_r <= cand[W*N-1 -: W];
      bus.adc_o <= cand;
      if (bus.train_start) begin
        state <= TRAIN;
        cfg <= '0;
        wcnt <= '0;
        pcnt <= '0;
        bus.locked <= 1'b0;
        bus.adc_o_valid <= 1'b0;
        bus.align_fail <= 1'b0;
      end else if (state == TRAIN) begin
        // the first two cycles of a window still hold data muxed under the previous cfg
        if (!(|wcnt[WW-1:1])) wcnt <= wcnt + 1'b1;
        else if (pcnt_nxt == PMAX) begin
          state <= LOCKED;
          pcnt <= pcnt_nxt;
          bus.locked <= 1'b1;
          bus.adc_o_valid <= 1'b1;
        end else if (wcnt == WMAX) begin
          wcnt <= '0;
          pcnt <= '0;
          if (cfg == 2'd3) begin
            state <= FAIL;
            bus.align_fail <= 1'b1;
          end else cfg <= cfg + 1'b1;
        end else begin
          pcnt <= pcnt_nxt;
          wcnt <= wcnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_adc_word_align.sv
// tb_adc_word_align: directed ramp scenarios with a queued expected-word scoreboard for adc_word_align
module tb_adc_word_align;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int mode = 0;
  int corr = 0;
  bit wrap_seen = 1'b0;
  logic [31:0] exp_q[$];
  adc_word_align_if #(.ADC_DATA_WIDTH(8), .PATH_NUM(2)) bus ();
  adc_word_align #(.ADC_DATA_WIDTH(8), .PATH_NUM(2), .CHECK_LEN(64), .WINDOW(256)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_out(input string t, input logic l, input logic v, input logic f, input logic [1:0] c);
    chk({t, "_locked"}, {31'd0, bus.locked}, {31'd0, l});
    chk({t, "_valid"}, {31'd0, bus.adc_o_valid}, {31'd0, v});
    chk({t, "_fail"}, {31'd0, bus.align_fail}, {31'd0, f});
    chk({t, "_cfg"}, {30'd0, bus.align_cfg}, {30'd0, c});
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic pulse(input int m);
    tick(1);
    mode = m;
    bus.train_start = 1'b1;
    tick(1);
    bus.train_start = 1'b0;
  endtask
  task automatic wait_for(input string name, input bit on_fail, input int exp_cnt);
    int cnt = 0;
    while (cnt <= 1100 && !(on_fail ? bus.align_fail : bus.locked)) begin
      tick(1);
      cnt++;
    end
    chk(name, cnt, exp_cnt);
  endtask
  // ramp source: word t holds samples 4t..4t+3; modes pick lane packing and skew
  initial begin : drive
    logic [7:0] b;
    b = 8'd0;
    bus.adc_in_H = '0;
    bus.adc_in_L = '0;
    bus.train_start = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: begin bus.adc_in_H = {b + 8'd2, b}; bus.adc_in_L = {b + 8'd3, b + 8'd1}; end
        1: begin bus.adc_in_H = {b + 8'd2, b}; bus.adc_in_L = {b + 8'd7, b + 8'd5}; end
        2: begin bus.adc_in_H = {b + 8'd3, b + 8'd1}; bus.adc_in_L = {b + 8'd6, b + 8'd4}; end
        default: begin bus.adc_in_H = 16'h5A5A; bus.adc_in_L = 16'h5A5A; end
      endcase
      if (corr > 0) begin
        corr--;
        if (corr == 0) bus.adc_in_H[7:0] = ~bus.adc_in_H[7:0];
      end
      exp_q.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
      b += 8'd4;
    end
  end
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() >= 3) begin
        e = exp_q.pop_front();
        if (bus.adc_o_valid) begin
          chk("adc_o", bus.adc_o, e);
          if (e[7:0] == 8'hFC && bus.adc_o == e) wrap_seen = 1'b1;
        end
      end
    end
  end
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin : control
    #12;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("reset_adc_o", bus.adc_o, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    chk_out("idle", 1'b0, 1'b0, 1'b0, 2'd0);
    pulse(0);
    wait_for("lock_time_cfg0", 1'b0, 66);
    chk_out("lock_cfg0", 1'b1, 1'b1, 1'b0, 2'd0);
    tick(20);
    pulse(0);
    chk_out("restart", 1'b0, 1'b0, 1'b0, 2'd0);
    wait_for("relock_time", 1'b0, 66);
    chk_out("relock", 1'b1, 1'b1, 1'b0, 2'd0);
    tick(10);
    #1 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("async_rst_adc_o", bus.adc_o, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(10);
    chk_out("post_rst_idle", 1'b0, 1'b0, 1'b0, 2'd0);
    pulse(0);
    wait_for("lock_time_after_rst", 1'b0, 66);
    chk_out("lock_after_rst", 1'b1, 1'b1, 1'b0, 2'd0);
    tick(10);
    pulse(1);
    wait_for("lock_time_dly", 1'b0, 578);
    chk_out("lock_dly", 1'b1, 1'b1, 1'b0, 2'd2);
    tick(20);
    wrap_seen = 1'b0;
    pulse(2);
    wait_for("lock_time_swap_dly", 1'b0, 834);
    chk_out("lock_swap_dly", 1'b1, 1'b1, 1'b0, 2'd3);
    tick(80);
    chk("wrap_seen", {31'd0, wrap_seen}, 32'd1);
    pulse(3);
    wait_for("fail_time", 1'b1, 1024);
    chk_out("fail", 1'b0, 1'b0, 1'b1, 2'd3);
    pulse(0);
    corr = 41;
    wait_for("lock_time_after_err", 1'b0, 107);
    chk_out("lock_after_err", 1'b1, 1'b1, 1'b0, 2'd0);
    tick(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
